// File: rtl/dsp_ctrl.sv
// DSP48 job sequencer: issues len operand reads / result writes, drains the pipeline, then pulses done.
// Optional macro DSP_ACC_EN: accumulate (dot-product) mode with a single result write at address 0.
module dsp_ctrl #(
  parameter int ADDR_WIDTH    = 5,
  parameter int ALUMODE_WIDTH = 4,
  parameter int OPMODE_WIDTH  = 7,
  parameter int INMODE_WIDTH  = 5,
  parameter int DRAIN_CYCLES  = 4,
  parameter logic [OPMODE_WIDTH-1:0] OP_MUL = 7'b0000101,
  parameter logic [OPMODE_WIDTH-1:0] OP_MAC = 7'b0100101
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [ADDR_WIDTH-1:0]    len_i,
  input  logic                     abort_i,
  output logic [ADDR_WIDTH-1:0]    bram0_r_addr_o,
  output logic                     bram1_web_o,
  output logic [ADDR_WIDTH-1:0]    bram1_w_addr_o,
  output logic [ALUMODE_WIDTH-1:0] alumode_o,
  output logic [OPMODE_WIDTH-1:0]  opmode_o,
  output logic [INMODE_WIDTH-1:0]  inmode_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [ADDR_WIDTH-1:0]   len;
  logic [DCW-1:0]          drain_cnt;

  // Controls for the element issued in the coming cycle; outputs are registered from these.
  logic [ADDR_WIDTH-1:0]   iss_idx;
  logic [ADDR_WIDTH-1:0]   iss_len;
  logic                    iss_last;
  logic                    iss_web;
  logic [ADDR_WIDTH-1:0]   iss_waddr;
  logic [OPMODE_WIDTH-1:0] iss_opmode;

  always_comb begin
    iss_idx    = (state == IDLE) ? '0 : idx + 1'b1;
    iss_len    = (state == IDLE) ? len_i : len;
    iss_last   = (iss_idx == iss_len - 1'b1);
`ifdef DSP_ACC_EN
    iss_web    = iss_last;
    iss_waddr  = '0;
    iss_opmode = (iss_idx == '0) ? OP_MUL : OP_MAC;
`else
    iss_web    = 1'b1;
    iss_waddr  = iss_idx;
    iss_opmode = OP_MUL;
`endif
  end

`ifndef DSP_ACC_EN
  logic unused_op_mac;
  assign unused_op_mac = ^OP_MAC;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      idx            <= '0;
      len            <= '0;
      drain_cnt      <= '0;
      bram0_r_addr_o <= '0;
      bram1_web_o    <= 1'b0;
      bram1_w_addr_o <= '0;
      alumode_o      <= '0;
      opmode_o       <= '0;
      inmode_o       <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      // Outputs fall back to idle values unless the next state drives them.
      bram0_r_addr_o <= '0;
      bram1_web_o    <= 1'b0;
      bram1_w_addr_o <= '0;
      alumode_o      <= '0;
      opmode_o       <= '0;
      inmode_o       <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !abort_i) begin
            if (len_i != '0) begin
              state          <= RUN;
              idx            <= '0;
              len            <= len_i;
              busy_o         <= 1'b1;
              bram0_r_addr_o <= iss_idx;
              bram1_web_o    <= iss_web;
              bram1_w_addr_o <= iss_waddr;
              opmode_o       <= iss_opmode;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort_i) begin
            state <= IDLE;
          end else if (idx == len - 1'b1) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            busy_o    <= 1'b1;
          end else begin
            idx            <= iss_idx;
            busy_o         <= 1'b1;
            bram0_r_addr_o <= iss_idx;
            bram1_web_o    <= iss_web;
            bram1_w_addr_o <= iss_waddr;
            opmode_o       <= iss_opmode;
          end
        end
        DRAIN: begin
          if (abort_i) begin
            state <= IDLE;
          end else if (drain_cnt == DCW'(DRAIN_CYCLES - 1)) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
            busy_o    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
